// File: rtl/evm_pkg.sv
// Shared types and helpers for the voting machine controller and its tally bank.
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKOUT = 2'd1,
        RESULT  = 2'd2
    } state_e;

    localparam int NUM_CAND_DEF = 5;
    localparam int CNT_W_DEF    = 8;

    // True when no more than one bit is set; callers zero-extend narrower vectors.
    function automatic logic at_most_one(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction

    // Position of the highest set bit; only meaningful when at_most_one() holds.
    function automatic logic [4:0] onehot_index(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/evm_tally_bank.sv
// Per-candidate saturating vote counters with a sticky overflow flag.
module evm_tally_bank
    import evm_pkg::*;
#(
    parameter int NUM_CAND = NUM_CAND_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data,
    output logic             overflow
);

    logic [CNT_W-1:0] tally_q [NUM_CAND];
    logic [CNT_W-1:0] tally_d [NUM_CAND];
    logic             overflow_q;
    logic             overflow_d;

    always_comb begin
        tally_d    = tally_q;
        overflow_d = overflow_q;
        // A full counter holds its value; the attempted vote is flagged instead.
        if (inc) begin
            if (tally_q[inc_idx] == {CNT_W{1'b1}}) begin
                overflow_d = 1'b1;
            end else begin
                tally_d[inc_idx] = tally_q[inc_idx] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally_q[i] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            tally_q    <= tally_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_data  = tally_q[rd_idx];
    assign overflow = overflow_q;

endmodule

// File: rtl/evm_vote_controller.sv
// Voting machine sequencer: accepts single-candidate ballots, enforces a
// post-vote lockout, rejects spoiled ballots and displays tallies in result mode.
module evm_vote_controller
    import evm_pkg::*;
#(
    parameter int NUM_CAND    = NUM_CAND_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LOCK_CYCLES = 50_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] vote_valid,
    output logic [CNT_W-1:0]    LEDs,
    output logic                vote_ack,
    output logic                reject,
    output logic                overflow
);

    localparam int IDX_W  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic [CNT_W-1:0]   leds_q, leds_d;
    logic               ack_q, ack_d;
    logic               reject_q, reject_d;

    logic               vote_any;
    logic               vote_single;
    logic [IDX_W-1:0]   vote_idx;
    logic               inc;
    logic [CNT_W-1:0]   rd_data;

    assign vote_any    = |vote_valid;
    assign vote_single = vote_any && at_most_one(32'(vote_valid));
    assign vote_idx    = IDX_W'(onehot_index(32'(vote_valid)));

    evm_tally_bank #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .IDX_W    (IDX_W)
    ) u_tally_bank (
        .clock    (clock),
        .reset    (reset),
        .inc      (inc),
        .inc_idx  (vote_idx),
        .rd_idx   (sel_q),
        .rd_data  (rd_data),
        .overflow (overflow)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        lock_d   = lock_q;
        leds_d   = leds_q;
        ack_d    = ack_q;
        reject_d = 1'b0;
        inc      = 1'b0;
        unique case (state_q)
            // A valid vote takes priority over a simultaneous request for result mode.
            IDLE: begin
                if (vote_single) begin
                    inc     = 1'b1;
                    leds_d  = CNT_W'(1) << vote_idx;
                    ack_d   = 1'b1;
                    lock_d  = LOCK_W'(LOCK_CYCLES - 1);
                    state_d = LOCKOUT;
                end else if (vote_any) begin
                    reject_d = 1'b1;
                end else if (mode) begin
                    sel_d   = '0;
                    state_d = RESULT;
                end
            end
            LOCKOUT: begin
                if (lock_q == '0) begin
                    ack_d   = 1'b0;
                    leds_d  = '0;
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q - LOCK_W'(1);
                end
            end
            RESULT: begin
                leds_d = rd_data;
                if (vote_single) sel_d = vote_idx;
                if (!mode) begin
                    leds_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            lock_q   <= '0;
            leds_q   <= '0;
            ack_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            lock_q   <= lock_d;
            leds_q   <= leds_d;
            ack_q    <= ack_d;
            reject_q <= reject_d;
        end
    end

    assign LEDs     = leds_q;
    assign vote_ack = ack_q;
    assign reject   = reject_q;

endmodule

// File: tb/tb_evm_vote_controller.sv
// Directed bench for evm_vote_controller with a four-cycle lockout.
module tb_evm_vote_controller;

    localparam int NC   = 5;
    localparam int LOCK = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          mode;
    logic [NC-1:0] vote_valid;
    logic [7:0]    LEDs;
    logic          vote_ack;
    logic          reject;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    evm_vote_controller #(
        .NUM_CAND    (NC),
        .CNT_W       (8),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .vote_valid (vote_valid),
        .LEDs       (LEDs),
        .vote_ack   (vote_ack),
        .reject     (reject),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          mode;
        logic [NC-1:0] vv;
        logic [7:0]    leds;
        logic          ack;
        logic          rej;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mode = 1'b0; vote_valid = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic cast_vote(input int idx);
        vote_valid = NC'(1) << idx;
        step();
        vote_valid = '0;
        repeat (LOCK) step();
    endtask

    task automatic setv(input int k, input logic m, input logic [NC-1:0] v,
                        input logic [7:0] l, input logic a, input logic r);
        vecs[k].mode = m; vecs[k].vv = v; vecs[k].leds = l; vecs[k].ack = a; vecs[k].rej = r;
    endtask

    initial begin
        // Vote for cand2, lockout with an ignored pulse, a spoiled ballot, then display.
        setv(0,  1'b0, 5'b00100, 8'h04, 1'b1, 1'b0);
        setv(1,  1'b0, 5'b00000, 8'h04, 1'b1, 1'b0);
        setv(2,  1'b0, 5'b00001, 8'h04, 1'b1, 1'b0);
        setv(3,  1'b0, 5'b00000, 8'h04, 1'b1, 1'b0);
        setv(4,  1'b0, 5'b00000, 8'h00, 1'b0, 1'b0);
        setv(5,  1'b0, 5'b00011, 8'h00, 1'b0, 1'b1);
        setv(6,  1'b0, 5'b00000, 8'h00, 1'b0, 1'b0);
        setv(7,  1'b1, 5'b00000, 8'h00, 1'b0, 1'b0);
        setv(8,  1'b1, 5'b00000, 8'h00, 1'b0, 1'b0);
        setv(9,  1'b1, 5'b00100, 8'h00, 1'b0, 1'b0);
        setv(10, 1'b1, 5'b00000, 8'h01, 1'b0, 1'b0);
        setv(11, 1'b1, 5'b00011, 8'h01, 1'b0, 1'b0);
        setv(12, 1'b1, 5'b00000, 8'h01, 1'b0, 1'b0);
        setv(13, 1'b0, 5'b00000, 8'h00, 1'b0, 1'b0);
        setv(14, 1'b0, 5'b00000, 8'h00, 1'b0, 1'b0);

        do_reset();
        chk("reset_leds", LEDs, 8'h00);
        chk("reset_ack", vote_ack, 1'b0);
        chk("reset_reject", reject, 1'b0);
        chk("reset_overflow", overflow, 1'b0);

        for (int k = 0; k < 15; k++) begin
            mode = vecs[k].mode;
            vote_valid = vecs[k].vv;
            step();
            chk($sformatf("vec%0d_leds", k), LEDs, vecs[k].leds);
            chk($sformatf("vec%0d_ack", k), vote_ack, vecs[k].ack);
            chk($sformatf("vec%0d_reject", k), reject, vecs[k].rej);
            chk($sformatf("vec%0d_overflow", k), overflow, 1'b0);
        end
        vote_valid = '0;

        // Three votes for cand1, one for cand4, then browse the tallies.
        do_reset();
        repeat (3) cast_vote(1);
        vote_valid = 5'b10000;
        step();
        chk("c4_vote_leds", LEDs, 8'h10);
        chk("c4_vote_ack", vote_ack, 1'b1);
        vote_valid = '0;
        repeat (LOCK) step();
        chk("c4_lock_end_ack", vote_ack, 1'b0);
        mode = 1'b1;
        step();
        vote_valid = 5'b00010;
        step();
        vote_valid = '0;
        step();
        chk("result_cand1", LEDs, 8'd3);
        vote_valid = 5'b10000;
        step();
        vote_valid = '0;
        chk("sel_latency_old", LEDs, 8'd3);
        step();
        chk("result_cand4", LEDs, 8'd1);
        mode = 1'b0;
        step();
        chk("result_exit_leds", LEDs, 8'h00);

        // Saturation of cand3.
        do_reset();
        repeat (255) cast_vote(3);
        chk("ovf_before_256", overflow, 1'b0);
        vote_valid = 5'b01000;
        step();
        vote_valid = '0;
        chk("ovf_after_256", overflow, 1'b1);
        chk("ovf_vote_ack", vote_ack, 1'b1);
        repeat (LOCK) step();
        mode = 1'b1;
        step();
        vote_valid = 5'b01000;
        step();
        vote_valid = '0;
        step();
        chk("saturated_tally", LEDs, 8'hFF);
        chk("ovf_sticky", overflow, 1'b1);
        mode = 1'b0;
        step();

        // Vote and mode request together: vote wins, result after lockout.
        do_reset();
        chk("reset_clears_ovf", overflow, 1'b0);
        mode = 1'b1;
        vote_valid = 5'b00001;
        step();
        vote_valid = '0;
        chk("vote_mode_leds", LEDs, 8'h01);
        chk("vote_mode_ack", vote_ack, 1'b1);
        repeat (LOCK - 1) step();
        chk("vote_mode_still_lock", vote_ack, 1'b1);
        step();
        chk("vote_mode_lock_end_leds", LEDs, 8'h00);
        chk("vote_mode_lock_end_ack", vote_ack, 1'b0);
        step();
        step();
        chk("vote_mode_result_tally0", LEDs, 8'h01);
        mode = 1'b0;
        step();

        // Reset in the middle of a lockout.
        vote_valid = 5'b00100;
        step();
        vote_valid = '0;
        step();
        chk("mid_lock_ack", vote_ack, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_leds", LEDs, 8'h00);
        chk("mid_reset_ack", vote_ack, 1'b0);
        chk("mid_reset_reject", reject, 1'b0);
        chk("mid_reset_overflow", overflow, 1'b0);
        vote_valid = 5'b00010;
        step();
        vote_valid = '0;
        chk("post_reset_vote_leds", LEDs, 8'h02);
        chk("post_reset_vote_ack", vote_ack, 1'b1);
        repeat (LOCK) step();
        mode = 1'b1;
        step();
        step();
        chk("post_reset_tally0", LEDs, 8'h00);
        mode = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/evm_vote_controller.md
# evm_vote_controller

Central sequencer of the electronic voting machine. Takes the debounced, one-cycle validation pulses from the per-candidate button_control instances and records each vote as a tally per candidate. It enforces one vote per voter with a lockout window and rejects ballots with more than one candidate pressed. In result mode it drives the 8 LEDs with the selected candidate's tally.

## Interface
- NUM_CAND, 5, number of candidates / validation inputs
- CNT_W, 8, tally width per candidate; must equal LED width (8)
- LOCK_CYCLES, 50_000_000, lockout length in clock cycles after an accepted vote (≥1)

- clock  input  1  single system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state and tallies
- mode  input  1  0 = voting, 1 = result display; level-sampled
- vote_valid  input  NUM_CAND  one-cycle pulses from button_control, bit i = candidate i
- LEDs  output  8  registered display value
- vote_ack  output  1  high for the whole lockout after an accepted vote
- reject  output  1  one-cycle pulse on a spoiled ballot (≥2 bits of vote_valid set)
- overflow  output  1  sticky; set when any tally would exceed 2^CNT_W−1

## Operation
- States: IDLE, LOCKOUT, RESULT.
- Reset: state IDLE, all tallies 0, sel 0, lock counter 0, LEDs 0, vote_ack 0, reject 0, overflow 0.
- IDLE:
  - exactly one vote_valid bit i set: tally[i] += 1 (saturate at 255, set overflow if already 255), LEDs ← one-hot (1<<i), vote_ack ← 1, lock counter ← LOCK_CYCLES−1, go to LOCKOUT.
  - ≥2 bits set: no tally change, reject pulses 1 cycle, stay IDLE, LEDs unchanged.
  - no bits set and mode=1: go to RESULT, sel ← 0.
  - A vote in the same cycle as mode=1 wins; the mode change is taken after lockout.
- LOCKOUT:
  - All vote_valid ignored (no reject, no tally change).
  - Lock counter decrements each cycle. When it reaches 0: vote_ack ← 0, LEDs ← 0, go to IDLE.
  - mode is not sampled.
- RESULT:
  - LEDs ← tally[sel] every cycle.
  - Exactly one vote_valid bit i set: sel ← i. Multi-hot is ignored, with no reject.
  - Tallies are never modified.
  - mode=0: go to IDLE, LEDs ← 0.
- Saturation: tallies never wrap; overflow is cleared only by reset.
- Reset asserted in any state overrides everything on that edge.

## Timing
- vote_valid pulse at edge N is sampled, and at edge N+1 tally, LEDs and vote_ack are updated and state is LOCKOUT (latency 1).
- vote_ack is high for exactly LOCK_CYCLES cycles. The first vote accepted after that has its pulse sampled no earlier than edge N+1+LOCK_CYCLES.
- reject is high for exactly the one cycle after the sampling edge.
- RESULT entry: mode=1 sampled at edge N in IDLE. State is RESULT after edge N+1, and LEDs = tally[0] after edge N+2.
- sel change: LEDs show the new candidate 2 edges after the pulse.
- No combinational path from inputs to outputs.

## Structure
- Package evm_pkg:
  - state enum (IDLE, LOCKOUT, RESULT)
  - defaults NUM_CAND=5, CNT_W=8
  - function for onehot/multi-hot detection (popcount ≤1 check)
- Sub-module evm_tally_bank:
  - NUM_CAND × CNT_W saturating counters
  - inputs: inc strobe, index
  - outputs: read port by index, overflow flag
- The controller FSM and lockout counter stay in evm_vote_controller.

## Test plan
All scenarios use LOCK_CYCLES=4.
- Reset then single pulse on bit 2 → next cycle LEDs=8'b0000_0100, vote_ack=1 for 4 cycles, tally[2]=1; then LEDs=0, state IDLE.
- Pulse on bit 0 during LOCKOUT (cycle 2 of 4) → tally[0] stays 0, reject stays 0.
- vote_valid=5'b00011 in IDLE → reject high 1 cycle, all tallies 0, vote_ack 0.
- Votes 3× cand1 and 1× cand4, then mode=1 → LEDs=3. Pulse bit 4 → LEDs=1 two edges later. mode=0 → LEDs=0.
- 256 accepted votes for cand3 → tally[3]=255, overflow=1 after the 256th; RESULT with sel=3 shows 8'hFF.
- Vote pulse and mode=1 in the same IDLE cycle → vote counted, RESULT entered only after lockout ends. Reset asserted mid-LOCKOUT → all outputs 0 next edge, state IDLE.
